// File: rtl/regfile_access_arbiter_pkg.sv
// rtl/regfile_access_arbiter_pkg.sv - widths, FSM encodings and shared types for the regfile access arbiter
package regfile_access_arbiter_pkg;

    localparam int DATA_INDEX_LIMIT     = 31;
    localparam int REG_ADDR_INDEX_LIMIT = 4;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_ISSUE   = 2'd1;
    localparam logic [ST_W-1:0] ST_CAPTURE = 2'd2;
    localparam logic [ST_W-1:0] ST_CLEAR   = 2'd3;

    typedef logic [DATA_INDEX_LIMIT:0]     data_t;
    typedef logic [REG_ADDR_INDEX_LIMIT:0] addr_t;

    typedef struct packed {
        logic  wr;
        addr_t addr1;
        addr_t addr2;
        data_t wdata;
    } op_t;

    function automatic logic is_last_addr(input addr_t a);
        return a == '1;
    endfunction

endpackage

// File: rtl/regfile_access_arbiter_if.sv
// rtl/regfile_access_arbiter_if.sv - requester, clear-control and register-file port bundle
interface regfile_access_arbiter_if;
    import regfile_access_arbiter_pkg::*;

    logic  a_req, a_wr, b_req, b_wr;
    addr_t a_addr1, a_addr2, b_addr1, b_addr2;
    data_t a_wdata, b_wdata;
    logic  a_gnt, b_gnt, a_done, b_done;
    data_t rdata1, rdata2;
    logic  clr_req, clr_busy, clr_done;
    logic  rf_read, rf_write;
    addr_t rf_addr_r1, rf_addr_r2, rf_addr_w;
    data_t rf_data_w, rf_data_r1, rf_data_r2;

    modport slave (
        input  a_req, a_wr, a_addr1, a_addr2, a_wdata,
        input  b_req, b_wr, b_addr1, b_addr2, b_wdata,
        output a_gnt, b_gnt, a_done, b_done, rdata1, rdata2,
        input  clr_req,
        output clr_busy, clr_done,
        output rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w,
        input  rf_data_r1, rf_data_r2
    );

    modport master (
        output a_req, a_wr, a_addr1, a_addr2, a_wdata,
        output b_req, b_wr, b_addr1, b_addr2, b_wdata,
        input  a_gnt, b_gnt, a_done, b_done, rdata1, rdata2,
        output clr_req,
        input  clr_busy, clr_done,
        input  rf_read, rf_write, rf_addr_r1, rf_addr_r2, rf_addr_w, rf_data_w,
        output rf_data_r1, rf_data_r2
    );

endinterface

// File: rtl/regfile_access_arbiter_rr_arbiter_2.sv
// rtl/regfile_access_arbiter_rr_arbiter_2.sv - two-way round-robin grant with last-grant pointer
module rr_arbiter_2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic gnt_a,
    output logic gnt_b
);

    logic prio_b_q, prio_b_d;

    // prio_b_q set means A won last time, so B wins the next tie
    assign gnt_a = req_a & (~req_b | ~prio_b_q);
    assign gnt_b = req_b & (~req_a |  prio_b_q);

    always_comb begin
        prio_b_d = prio_b_q;
        if (take) begin
            prio_b_d = gnt_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - arbitrates two requesters and a clear sweep onto one register-file port
module regfile_access_arbiter
    import regfile_access_arbiter_pkg::*;
#(
    parameter data_t CLR_VALUE = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_access_arbiter_if.slave  bus
);

    logic [ST_W-1:0] state_q, state_d;
    op_t             op_q, op_d;
    logic            owner_b_q, owner_b_d;
    addr_t           cnt_q, cnt_d;
    logic            clr_pend_q, clr_pend_d;
    logic            a_done_q, a_done_d, b_done_q, b_done_d;
    logic            clr_done_q, clr_done_d;
    data_t           rdata1_q, rdata1_d, rdata2_q, rdata2_d;

    logic            clr_now, take, arb_gnt_a, arb_gnt_b;
    logic            rf_read, rf_write;

    // a pending clear outranks both requesters; no grant is issued in a reset cycle
    assign clr_now = bus.clr_req | clr_pend_q;
    assign take    = (state_q == ST_IDLE) & ~rst & ~clr_now & (bus.a_req | bus.b_req);

    rr_arbiter_2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_a (bus.a_req),
        .req_b (bus.b_req),
        .take  (take),
        .gnt_a (arb_gnt_a),
        .gnt_b (arb_gnt_b)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        owner_b_d  = owner_b_q;
        cnt_d      = cnt_q;
        clr_pend_d = clr_pend_q;
        a_done_d   = 1'b0;
        b_done_d   = 1'b0;
        clr_done_d = 1'b0;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        rf_read    = 1'b0;
        rf_write   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_now) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    clr_pend_d = 1'b0;
                end else if (take) begin
                    state_d   = ST_ISSUE;
                    owner_b_d = arb_gnt_b;
                    op_d      = arb_gnt_b ? '{bus.b_wr, bus.b_addr1, bus.b_addr2, bus.b_wdata}
                                          : '{bus.a_wr, bus.a_addr1, bus.a_addr2, bus.a_wdata};
                end
            end
            ST_ISSUE: begin
                rf_read  = ~op_q.wr;
                rf_write =  op_q.wr;
                if (bus.clr_req) begin
                    clr_pend_d = 1'b1;
                end
                if (op_q.wr) begin
                    state_d  = ST_IDLE;
                    a_done_d = ~owner_b_q;
                    b_done_d =  owner_b_q;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.clr_req) begin
                    clr_pend_d = 1'b1;
                end
                rdata1_d = bus.rf_data_r1;
                rdata2_d = bus.rf_data_r2;
                a_done_d = ~owner_b_q;
                b_done_d =  owner_b_q;
                state_d  = ST_IDLE;
            end
            ST_CLEAR: begin
                rf_write = 1'b1;
                // counter holds at 31 on exit rather than wrapping
                if (is_last_addr(cnt_q)) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            owner_b_q  <= 1'b0;
            cnt_q      <= '0;
            clr_pend_q <= 1'b0;
            a_done_q   <= 1'b0;
            b_done_q   <= 1'b0;
            clr_done_q <= 1'b0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            owner_b_q  <= owner_b_d;
            cnt_q      <= cnt_d;
            clr_pend_q <= clr_pend_d;
            a_done_q   <= a_done_d;
            b_done_q   <= b_done_d;
            clr_done_q <= clr_done_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
        end
    end

    assign bus.a_gnt      = take & arb_gnt_a;
    assign bus.b_gnt      = take & arb_gnt_b;
    assign bus.a_done     = a_done_q;
    assign bus.b_done     = b_done_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.rdata2     = rdata2_q;
    assign bus.clr_busy   = (state_q == ST_CLEAR);
    assign bus.clr_done   = clr_done_q;
    assign bus.rf_read    = rf_read;
    assign bus.rf_write   = rf_write;
    assign bus.rf_addr_r1 = op_q.addr1;
    assign bus.rf_addr_r2 = op_q.addr2;
    assign bus.rf_addr_w  = (state_q == ST_CLEAR) ? cnt_q : op_q.addr1;
    assign bus.rf_data_w  = (state_q == ST_CLEAR) ? CLR_VALUE : op_q.wdata;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb/tb_regfile_access_arbiter.sv - directed bench with a cycle-schedule model of the regfile access arbiter
module tb_regfile_access_arbiter;
    import regfile_access_arbiter_pkg::*;

    localparam logic [31:0] CLR = 32'hA5A5_0F0F;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_access_arbiter_if bus ();

    regfile_access_arbiter #(.CLR_VALUE(CLR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nchk = 0;
    int nerr = 0;

    function automatic logic [31:0] init_val(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // register file: one-cycle registered read, write at the edge
    logic [31:0] env_mem [32];
    bit env_init = 1'b0;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
            env_init <= 1'b1;
        end else if (bus.rf_write === 1'b1) begin
            env_mem[bus.rf_addr_w] <= bus.rf_data_w;
        end
        if (bus.rf_read === 1'b1) begin
            bus.rf_data_r1 <= env_mem[bus.rf_addr_r1];
            bus.rf_data_r2 <= env_mem[bus.rf_addr_r2];
        end
    end

    // model: per-cycle schedule of expected outputs, filled when an operation is accepted
    bit          e_ga [N], e_gb [N], e_da [N], e_db [N], e_rd [N], e_wr [N], e_busy [N], e_cd [N], e_rset [N];
    logic [4:0]  e_aw [N], e_ar1 [N], e_ar2 [N];
    logic [31:0] e_dw [N], e_rv1 [N], e_rv2 [N];
    logic [31:0] mmem [32];
    bit          minit = 1'b0, checking = 1'b0, prio_b = 1'b0, pend = 1'b0;
    int          free_at = 0, clr_lo = 1, clr_hi = 0;
    logic [31:0] x_rd1 = '0, x_rd2 = '0;
    bit          rec = 1'b0;
    bit          gseq [$];
    int          nclr = 0;

    task automatic decide(input int t);
        bit win_b, wr;
        logic [4:0] a1, a2;
        logic [31:0] wd;
        if (t >= free_at) begin
            if (bus.clr_req || pend) begin
                pend = 1'b0;
                for (int k = 0; k < 32; k++) begin
                    e_wr[t+1+k] = 1'b1; e_aw[t+1+k] = 5'(k); e_dw[t+1+k] = CLR; e_busy[t+1+k] = 1'b1;
                end
                e_cd[t+33] = 1'b1;
                free_at = t + 33; clr_lo = t + 1; clr_hi = t + 32;
            end else if (bus.a_req || bus.b_req) begin
                win_b = bus.b_req && (!bus.a_req || prio_b);
                prio_b = !win_b;
                wr = win_b ? bus.b_wr : bus.a_wr;
                a1 = win_b ? bus.b_addr1 : bus.a_addr1;
                a2 = win_b ? bus.b_addr2 : bus.a_addr2;
                wd = win_b ? bus.b_wdata : bus.a_wdata;
                if (win_b) e_gb[t] = 1'b1; else e_ga[t] = 1'b1;
                if (wr) begin
                    e_wr[t+1] = 1'b1; e_aw[t+1] = a1; e_dw[t+1] = wd;
                    if (win_b) e_db[t+2] = 1'b1; else e_da[t+2] = 1'b1;
                    free_at = t + 2;
                end else begin
                    e_rd[t+1] = 1'b1; e_ar1[t+1] = a1; e_ar2[t+1] = a2;
                    if (win_b) e_db[t+3] = 1'b1; else e_da[t+3] = 1'b1;
                    e_rset[t+3] = 1'b1; e_rv1[t+3] = mmem[a1]; e_rv2[t+3] = mmem[a2];
                    free_at = t + 3;
                end
            end
        end else if (bus.clr_req && !(t >= clr_lo && t <= clr_hi)) begin
            pend = 1'b1;
        end
    endtask

    task automatic compare(input int t);
        chk("a_gnt",    32'(bus.a_gnt),    32'(e_ga[t]));
        chk("b_gnt",    32'(bus.b_gnt),    32'(e_gb[t]));
        chk("a_done",   32'(bus.a_done),   32'(e_da[t]));
        chk("b_done",   32'(bus.b_done),   32'(e_db[t]));
        chk("rf_read",  32'(bus.rf_read),  32'(e_rd[t]));
        chk("rf_write", 32'(bus.rf_write), 32'(e_wr[t]));
        chk("clr_busy", 32'(bus.clr_busy), 32'(e_busy[t]));
        chk("clr_done", 32'(bus.clr_done), 32'(e_cd[t]));
        chk("rdata1",   bus.rdata1, x_rd1);
        chk("rdata2",   bus.rdata2, x_rd2);
        chk("rw_excl",  32'(bus.rf_read & bus.rf_write), 32'd0);
        chk("one_gnt",  32'(bus.a_gnt & bus.b_gnt), 32'd0);
        chk("one_done", 32'(bus.a_done & bus.b_done), 32'd0);
        if (e_wr[t]) begin
            chk("rf_addr_w", 32'(bus.rf_addr_w), 32'(e_aw[t]));
            chk("rf_data_w", bus.rf_data_w, e_dw[t]);
        end
        if (e_rd[t]) begin
            chk("rf_addr_r1", 32'(bus.rf_addr_r1), 32'(e_ar1[t]));
            chk("rf_addr_r2", 32'(bus.rf_addr_r2), 32'(e_ar2[t]));
        end
    endtask

    always @(negedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 32; i++) mmem[i] = init_val(i);
            minit = 1'b1;
        end
        if (cyc > N - 64) begin
            $display("FAIL cycle_budget: got %0d cycles expected below %0d", cyc, N - 64);
            $fatal(1);
        end
        if (checking && !rst) decide(cyc);
        if (e_rset[cyc]) begin
            x_rd1 = e_rv1[cyc];
            x_rd2 = e_rv2[cyc];
        end
        if (checking) compare(cyc);
        if (rec && bus.a_gnt) gseq.push_back(1'b0);
        if (rec && bus.b_gnt) gseq.push_back(1'b1);
        if (bus.clr_busy === 1'b1 && bus.rf_write === 1'b1) nclr++;
        if (e_wr[cyc]) mmem[e_aw[cyc]] = e_dw[cyc];
        if (rst) begin
            checking = 1'b1;
            for (int k = cyc + 1; k <= cyc + 40; k++) begin
                e_ga[k] = 0; e_gb[k] = 0; e_da[k] = 0; e_db[k] = 0; e_rd[k] = 0;
                e_wr[k] = 0; e_busy[k] = 0; e_cd[k] = 0; e_rset[k] = 0;
            end
            e_rset[cyc+1] = 1'b1; e_rv1[cyc+1] = '0; e_rv2[cyc+1] = '0;
            free_at = cyc + 1; prio_b = 1'b0; pend = 1'b0; clr_lo = 1; clr_hi = 0;
        end
    end

    task automatic req_op(input bit who_b, input bit wr, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] wd, output int gcyc);
        if (who_b) begin
            bus.b_wr = wr; bus.b_addr1 = a1; bus.b_addr2 = a2; bus.b_wdata = wd; bus.b_req = 1'b1;
        end else begin
            bus.a_wr = wr; bus.a_addr1 = a1; bus.a_addr2 = a2; bus.a_wdata = wd; bus.a_req = 1'b1;
        end
        gcyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((who_b ? bus.b_gnt : bus.a_gnt) === 1'b1) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) begin
            nchk++; nerr++;
            $display("FAIL gnt_timeout: got no grant expected grant within 100 cycles");
        end
        @(posedge clk); #1;
        if (who_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
    endtask

    task automatic wait_done(input bit who_b, output int dcyc, output logic [31:0] r1, output logic [31:0] r2);
        dcyc = -1; r1 = 'x; r2 = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((who_b ? bus.b_done : bus.a_done) === 1'b1) begin
                dcyc = cyc; r1 = bus.rdata1; r2 = bus.rdata2;
                break;
            end
        end
        if (dcyc < 0) begin
            nchk++; nerr++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic agent(input bit who_b);
        int g;
        for (int i = 0; i < 4; i++) begin
            req_op(who_b, 1'b1, who_b ? 5'(20 + i) : 5'(10 + i), 5'd0, {16'hBB00 * 16'(who_b), 16'(i)}, g);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g, d, c0, dc;
        logic [31:0] r1, r2;
        bus.a_req = 0; bus.a_wr = 0; bus.a_addr1 = 0; bus.a_addr2 = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_wr = 0; bus.b_addr1 = 0; bus.b_addr2 = 0; bus.b_wdata = 0;
        bus.clr_req = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("rst_rf_write", 32'(bus.rf_write), 32'd0);
        chk("rst_rdata1", bus.rdata1, 32'd0);
        @(posedge clk); #1;

        req_op(1'b0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, g);
        wait_done(1'b0, d, r1, r2);
        chk("wr_latency", 32'(d - g), 32'd2);
        chk("wr_mem_r5", env_mem[5], 32'hDEADBEEF);

        req_op(1'b0, 1'b0, 5'd5, 5'd0, 32'h0, g);
        wait_done(1'b0, d, r1, r2);
        chk("rd_latency", 32'(d - g), 32'd3);
        chk("rd_data1", r1, 32'hDEADBEEF);
        chk("rd_data2", r2, 32'h1000_0000);

        req_op(1'b1, 1'b0, 5'd9, 5'd10, 32'h0, g);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_b_done", 32'(bus.b_done), 32'd0);
            chk("abort_rdata1", bus.rdata1, 32'd0);
            chk("abort_rdata2", bus.rdata2, 32'd0);
        end
        @(posedge clk); #1;

        gseq.delete();
        rec = 1'b1;
        fork
            agent(1'b0);
            agent(1'b1);
        join
        repeat (4) @(posedge clk);
        #1 rec = 1'b0;
        chk("rr_len", 32'(gseq.size()), 32'd8);
        for (int i = 0; i < 8 && i < gseq.size(); i++) chk("rr_order", 32'(gseq[i]), 32'(i % 2));
        chk("rr_mem_a", env_mem[13], 32'h0000_0003);
        chk("rr_mem_b", env_mem[23], 32'hBB00_0003);

        req_op(1'b0, 1'b1, 5'd7, 5'd0, 32'h0000_7777, g);
        nclr = 0;
        bus.clr_req = 1'b1;
        @(posedge clk); #1 bus.clr_req = 1'b0;
        dc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.clr_done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        chk("pend_clr_done_cycle", 32'(dc - g), 32'd35);
        chk("pend_clr_writes", 32'(nclr), 32'd32);
        @(posedge clk); #1;

        nclr = 0;
        c0 = cyc;
        bus.clr_req = 1'b1;
        fork
            begin
                @(posedge clk); #1 bus.clr_req = 1'b0;
            end
            req_op(1'b0, 1'b0, 5'd3, 5'd4, 32'h0, g);
        join
        chk("clr_before_a_gnt", 32'(g - c0), 32'd33);
        chk("clr_writes", 32'(nclr), 32'd32);
        wait_done(1'b0, d, r1, r2);
        chk("after_clr_rd1", r1, CLR);
        chk("after_clr_rd2", r2, CLR);

        for (int i = 0; i < 32; i++) begin
            req_op(1'b0, 1'b0, 5'(i), 5'(31 - i), 32'h0, g);
            wait_done(1'b0, d, r1, r2);
            chk("readback1", r1, CLR);
            chk("readback2", r2, CLR);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/regfile_access_arbiter.md
REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 Parameter: CLR_VALUE, 32'h0, word written to every register during a clear sweep.
REQ-002 CLK  input  1  single clock; all state updates on +ve edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 A_REQ, A_WR, A_ADDR1, A_ADDR2, A_WDATA  input  1/1/5/5/32  requester A (control unit): request, write(1)/read(0), read or write address, second read address, write data.
REQ-005 B_REQ, B_WR, B_ADDR1, B_ADDR2, B_WDATA  input  1/1/5/5/32  requester B (debug port), same meaning as A.
REQ-006 A_GNT, B_GNT  output  1 each  one-cycle pulse: request accepted.
REQ-007 A_DONE, B_DONE  output  1 each  one-cycle pulse: operation complete; read data valid.
REQ-008 RDATA1, RDATA2  output  32 each  captured read data, held until the next read completes.
REQ-009 CLR_REQ  input  1  request a sweep of all 32 registers to CLR_VALUE.
REQ-010 CLR_BUSY  output  1  high while a sweep is in progress; CLR_DONE  output  1  one-cycle pulse at sweep end.
REQ-011 RF_READ, RF_WRITE  output  1 each; RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W  output  5 each; RF_DATA_W  output  32; RF_DATA_R1, RF_DATA_R2  input  32 each: register-file port.

Function
REQ-012 FSM states IDLE, ISSUE, CAPTURE, CLEAR.
REQ-013 IDLE: priority CLR_REQ > requester A/B; CLR_REQ -> CLEAR, counter=0, CLR_BUSY=1 next cycle.
REQ-014 IDLE, no CLR_REQ, any X_REQ: pick winner, latch its op/addresses/data, pulse winner's GNT in that cycle, -> ISSUE.
REQ-015 A and B both requesting: round-robin; winner is the requester not granted last; after reset A has priority.
REQ-016 ISSUE: drive latched addresses/data for exactly one cycle; write -> RF_WRITE=1, RF_READ=0; read -> RF_READ=1, RF_WRITE=0.
REQ-017 ISSUE write -> IDLE, owner's DONE pulses in the cycle after ISSUE (grant-to-done latency 2 cycles).
REQ-018 ISSUE read -> CAPTURE; CAPTURE samples RF_DATA_R1/R2 into RDATA1/RDATA2 at its closing edge; owner's DONE pulses in the next cycle (grant-to-done latency 3 cycles), -> IDLE.
REQ-019 CLEAR: each cycle RF_WRITE=1, RF_ADDR_W=counter, RF_DATA_W=CLR_VALUE; counter increments; after address 31 -> IDLE, CLR_BUSY=0, CLR_DONE pulses (exactly 32 write cycles).
REQ-020 RF_READ and RF_WRITE SHALL never be 1 simultaneously; both 0 in IDLE.
REQ-021 Requests arriving outside IDLE are not granted; requesters hold X_REQ until GNT; no queueing.
REQ-022 CLR_REQ asserted during CLEAR is ignored; asserted during ISSUE/CAPTURE is serviced after the current op returns to IDLE.
REQ-023 Counter is 5 bits plus terminal detect; no wrap past 31.

Reset
REQ-024 RST=1 at a clock edge: state=IDLE, all GNT/DONE/CLR_DONE/CLR_BUSY=0, RF_READ=RF_WRITE=0, RDATA1/RDATA2=0, round-robin pointer favours A, counter=0.
REQ-025 RST mid-operation aborts it; no DONE or CLR_DONE is issued for the aborted operation.

Structure
REQ-026 State encodings and state-width constants SHALL live in prj_definition.v; data and address widths use the existing DATA_INDEX_LIMIT / REG_ADDR_INDEX_LIMIT.
REQ-027 One sub-module: rr_arbiter_2 (two-way round-robin grant with last-grant pointer).

Verification
REQ-028 Reset, A writes 32'hDEADBEEF to R5 -> A_GNT cycle 0, RF_WRITE=1 ADDR_W=5 cycle 1, A_DONE cycle 2.
REQ-029 A reads R5/R0 after write -> A_DONE cycle 3, RDATA1=32'hDEADBEEF, RDATA2=register-file R0 value.
REQ-030 A and B request continuously -> grants alternate A,B,A,B; neither starves.
REQ-031 CLR_REQ with A_REQ in IDLE -> CLEAR wins; 32 consecutive RF_WRITE cycles addr 0..31; CLR_DONE; then A_GNT; all registers read back CLR_VALUE.
REQ-032 RST asserted in CAPTURE -> next cycle IDLE, no DONE, RDATA1=RDATA2=0.
REQ-033 Every cycle check assertion: never RF_READ and RF_WRITE both 1; at most one GNT and one DONE per cycle.
